// File: rtl/pc_defs_pkg.sv
// Shared definitions for the fetch-stage PC unit: state encodings and default widths.
package pc_defs;
  localparam int DEF_PC_W    = 32;
  localparam int DEF_IMM_W   = 16;
  localparam int DEF_INDEX_W = 26;
  localparam int DEF_SHIFT   = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_ERROR  = 2'd2
  } pc_state_t;
endpackage

// File: rtl/branch_target_gen.sv
// Combinational branch/jump target generation: sign-extended immediate, beq/bne target, J target.
module branch_target_gen #(
  parameter int PC_W    = pc_defs::DEF_PC_W,
  parameter int IMM_W   = pc_defs::DEF_IMM_W,
  parameter int INDEX_W = pc_defs::DEF_INDEX_W,
  parameter int SHIFT   = pc_defs::DEF_SHIFT
) (
  input  logic [IMM_W-1:0]   imm,
  input  logic [PC_W-1:0]    branch_pc,
  input  logic [INDEX_W-1:0] jump_index,
  output logic [PC_W-1:0]    sign_ext,
  output logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    jump_target
);
  assign sign_ext      = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign branch_target = branch_pc + (sign_ext << SHIFT);
  // J-type keeps the region bits of the delay-slot PC above the shifted index
  assign jump_target   = {branch_pc[PC_W-1:INDEX_W+SHIFT], jump_index, {SHIFT{1'b0}}};
endmodule

// File: rtl/pc_branch_unit.sv
// Fetch-stage PC register with next-PC selection (sequential/branch/J/JR), stall, halt, step-enable.
// Optional JR alignment trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_branch_unit
  import pc_defs::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              IMM_W    = DEF_IMM_W,
  parameter int              INDEX_W  = DEF_INDEX_W,
  parameter int              SHIFT    = DEF_SHIFT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic               i_branch_taken,
  input  logic [IMM_W-1:0]   i_imm,
  input  logic [PC_W-1:0]    i_branch_pc,
  input  logic               i_jump,
  input  logic [INDEX_W-1:0] i_jump_index,
  input  logic               i_jr,
  input  logic [PC_W-1:0]    i_jr_target,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_plus,
  output logic [PC_W-1:0]    o_sign_extension,
  output logic [PC_W-1:0]    o_branch_target,
  output logic               o_flush,
`ifdef PC_ALIGN_CHECK_EN
  output logic               o_addr_err,
`endif
  output logic               o_halted
);
  localparam logic [PC_W-1:0] INSTR_BYTES = PC_W'(1) << SHIFT;

  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] jump_target;

  branch_target_gen #(
    .PC_W(PC_W), .IMM_W(IMM_W), .INDEX_W(INDEX_W), .SHIFT(SHIFT)
  ) u_tgt (
    .imm           (i_imm),
    .branch_pc     (i_branch_pc),
    .jump_index    (i_jump_index),
    .sign_ext      (o_sign_extension),
    .branch_target (o_branch_target),
    .jump_target   (jump_target)
  );

  assign o_pc_plus = pc_q + INSTR_BYTES;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    o_flush = 1'b0;
    if (i_enable && state_q == ST_RUN) begin
      if (i_halt) begin
        state_d = ST_HALTED;
      end else if (i_stall) begin
        pc_d = pc_q;
      end else if (i_jr) begin
`ifdef PC_ALIGN_CHECK_EN
        // Misaligned JR traps without redirecting; PC stays on the JR
        if ((i_jr_target & (INSTR_BYTES - PC_W'(1))) != '0) begin
          state_d = ST_ERROR;
        end else begin
          pc_d    = i_jr_target;
          o_flush = 1'b1;
        end
`else
        pc_d    = i_jr_target;
        o_flush = 1'b1;
`endif
      end else if (i_jump) begin
        pc_d    = jump_target;
        o_flush = 1'b1;
      end else if (i_branch_taken) begin
        pc_d    = o_branch_target;
        o_flush = 1'b1;
      end else begin
        pc_d = o_pc_plus;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign o_pc     = pc_q;
  assign o_halted = (state_q == ST_HALTED);
`ifdef PC_ALIGN_CHECK_EN
  assign o_addr_err = (state_q == ST_ERROR);
`endif
endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: expected PCs are queued at drive time, popped after the edge.
module tb_pc_branch_unit;
  logic        clk = 1'b0;
  logic        reset, enable, stall, halt, branch_taken, jump, jr;
  logic [15:0] imm;
  logic [31:0] branch_pc, jr_target;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus, sext, btgt;
  logic        flush, halted;
`ifdef PC_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  pc_branch_unit dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_stall(stall), .i_halt(halt),
    .i_branch_taken(branch_taken), .i_imm(imm), .i_branch_pc(branch_pc),
    .i_jump(jump), .i_jump_index(jump_index), .i_jr(jr), .i_jr_target(jr_target),
    .o_pc(pc), .o_pc_plus(pc_plus), .o_sign_extension(sext), .o_branch_target(btgt),
    .o_flush(flush),
`ifdef PC_ALIGN_CHECK_EN
    .o_addr_err(addr_err),
`endif
    .o_halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    stall = 0; halt = 0; branch_taken = 0; jump = 0; jr = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    reset = 0;
    sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
    repeat (3) begin
      tick();
      exp_pc = sb.pop_front();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, exp_pc); end
    end
    checks++; if (pc_plus !== 32'h10) begin errors++; $display("FAIL pc_plus got %h exp %h", pc_plus, 32'h10); end
  endtask

  task automatic test_branch();
    imm = 16'h8000; branch_pc = 32'h1204; branch_taken = 1; #1;
    checks++; if (sext !== 32'hFFFF8000) begin errors++; $display("FAIL sext_neg got %h exp %h", sext, 32'hFFFF8000); end
    checks++; if (btgt !== 32'hFFFE1204) begin errors++; $display("FAIL btgt_neg got %h exp %h", btgt, 32'hFFFE1204); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL branch_flush got %b exp 1", flush); end
    sb.push_back(32'hFFFE1204);
    tick(); clear_redirects();
    exp_pc = sb.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL branch_pc got %h exp %h", pc, exp_pc); end
  endtask

  task automatic test_stall();
    imm = 16'h4000; branch_pc = 32'h1204; #1;
    checks++; if (sext !== 32'h00004000) begin errors++; $display("FAIL sext_pos got %h exp %h", sext, 32'h4000); end
    checks++; if (btgt !== 32'h00011204) begin errors++; $display("FAIL btgt_pos got %h exp %h", btgt, 32'h11204); end
    stall = 1; branch_taken = 1; #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stall_flush got %b exp 0", flush); end
    checks++; if (btgt !== 32'h00011204) begin errors++; $display("FAIL stall_btgt got %h exp %h", btgt, 32'h11204); end
    sb.push_back(32'hFFFE1204); sb.push_back(32'hFFFE1204);
    repeat (2) begin
      tick();
      exp_pc = sb.pop_front();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL stall_pc got %h exp %h", pc, exp_pc); end
    end
    clear_redirects();
  endtask

  task automatic test_jump();
    jump = 1; jump_index = 26'h100; branch_pc = 32'h1204; branch_taken = 1; imm = 16'h0001; #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jump_flush got %b exp 1", flush); end
    sb.push_back(32'h00000400);
    tick();
    exp_pc = sb.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL jump_pc got %h exp %h", pc, exp_pc); end
    jr = 1; jr_target = 32'h2000;
    sb.push_back(32'h2000);
    tick(); clear_redirects();
    exp_pc = sb.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL jr_pc got %h exp %h", pc, exp_pc); end
    // back-to-back: branch then wrap through all-ones
    branch_taken = 1; branch_pc = 32'h0; imm = 16'hFFFF;
    sb.push_back(32'hFFFFFFFC); sb.push_back(32'h0); sb.push_back(32'h4);
    tick(); branch_taken = 0;
    exp_pc = sb.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL b2b_branch got %h exp %h", pc, exp_pc); end
    repeat (2) begin
      tick();
      exp_pc = sb.pop_front();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL wrap_pc got %h exp %h", pc, exp_pc); end
    end
  endtask

  task automatic test_halt();
    reset = 1; tick(); reset = 0;
    repeat (4) tick();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pre_halt_pc got %h exp %h", pc, 32'h10); end
    halt = 1; sb.push_back(32'h10);
    tick(); halt = 0;
    exp_pc = sb.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL halt_pc got %h exp %h", pc, exp_pc); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted got %b exp 1", halted); end
    jr = 1; jr_target = 32'h2000; jump = 1; branch_taken = 1;
    repeat (5) begin
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL halt_flush got %b exp 0", flush); end
      sb.push_back(32'h10);
      tick();
      exp_pc = sb.pop_front();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL halt_hold got %h exp %h", pc, exp_pc); end
    end
    clear_redirects();
    reset = 1; tick(); reset = 0;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL halt_reset_pc got %h exp 0", pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset_halted got %b exp 0", halted); end
  endtask

  task automatic test_enable();
    tick(); tick();
    enable = 0; jr = 1; jr_target = 32'h3000; imm = 16'h0001; branch_pc = 32'h0; #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL en_flush got %b exp 0", flush); end
    checks++; if (btgt !== 32'h4) begin errors++; $display("FAIL en_btgt got %h exp %h", btgt, 32'h4); end
    repeat (3) begin
      sb.push_back(32'h8);
      tick();
      exp_pc = sb.pop_front();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL en_freeze got %h exp %h", pc, exp_pc); end
    end
    reset = 1; tick(); reset = 0;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL en_reset got %h exp 0", pc); end
    enable = 1; clear_redirects();
  endtask

  task automatic test_align();
    tick();
    jr = 1; jr_target = 32'h1202;
`ifdef PC_ALIGN_CHECK_EN
    sb.push_back(32'h4); sb.push_back(32'h4);
`else
    sb.push_back(32'h1202); sb.push_back(32'h1206);
`endif
    tick(); jr = 0;
    exp_pc = sb.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL jr_misalign_pc got %h exp %h", pc, exp_pc); end
    tick();
    exp_pc = sb.pop_front();
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL jr_after_pc got %h exp %h", pc, exp_pc); end
`ifdef PC_ALIGN_CHECK_EN
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err got %b exp 1", addr_err); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL err_halted got %b exp 0", halted); end
    reset = 1; tick(); reset = 0;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_reset got %b exp 0", addr_err); end
`endif
  endtask

  initial begin
    reset = 1; enable = 1; clear_redirects();
    imm = '0; branch_pc = '0; jump_index = '0; jr_target = '0;
    test_reset();
    test_branch();
    test_stall();
    test_jump();
    test_halt();
    test_enable();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
